// File: rtl/next_pc_pkg.sv
// Shared types and helpers for the next-PC unit: target select encoding,
// default vectors and the absolute-jump target function.
package next_pc_pkg;

   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_J,
      SEL_JR,
      SEL_RET
   } sel_e;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

   // Widest PC the jump helper handles; callers zero-extend and truncate.
   localparam int MAX_W = 64;

   // Keep the pc_plus4 bits above the shifted imm26 field, splice in imm26,
   // and leave off_shift zero bits at the bottom.
   function automatic logic [MAX_W-1:0] calc_j_tgt(input logic [MAX_W-1:0] pc_plus4,
                                                    input logic [25:0]      imm26,
                                                    input int unsigned      off_shift);
      logic [MAX_W-1:0] upper;
      logic [MAX_W-1:0] field;
      upper = (pc_plus4 >> (26 + off_shift)) << (26 + off_shift);
      field = {{(MAX_W-26){1'b0}}, imm26} << off_shift;
      return upper | field;
   endfunction

endpackage

// File: rtl/next_pc_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// push+pop together replaces the top entry in place.
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    wr_idx;
   logic [CW-1:0]    count;

   assign wr_idx = pop ? ptr : ptr + 1'b1;

   // NOTE: the entry array has no reset; the count alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_idx] <= push_data;
   end

   // NOTE: non-blocking assignments keep ptr/count updates order-independent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               ptr   <= ptr + 1'b1;
               count <= full ? count : count + 1'b1;
            end
            2'b01: begin
               ptr   <= ptr - 1'b1;
               count <= count - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign top   = mem[ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/next_pc_unit.sv
// Registered, stallable next-PC generator with return-address prediction.
// Optional NEXT_PC_MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VEC.
module next_pc_unit
   import next_pc_pkg::*;
#(
   parameter int               ADDR_W    = 32,
   parameter int unsigned      OFF_SHIFT = 2,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
   parameter int               RAS_DEPTH = 4
`ifdef NEXT_PC_MISALIGN_TRAP_EN
  ,parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC)
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              pc_src,
   input  logic              jump,
   input  logic              jr,
   input  logic              link,
   input  logic              ret,
   input  logic [25:0]       imm26,
   input  logic [ADDR_W-1:0] sext_off,
   input  logic [ADDR_W-1:0] rs_val,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              ras_empty,
   output logic              ras_full
`ifdef NEXT_PC_MISALIGN_TRAP_EN
  ,output logic              misalign
`endif
);

   sel_e              sel;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] j_tgt;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] target;
   logic [MAX_W-1:0]  pc4_ext;
   logic [MAX_W-1:0]  j_ext;
   logic              ras_push;
   logic              ras_pop;

   assign pc_plus4 = pc + ADDR_W'(4);
   assign br_tgt   = pc_plus4 + (sext_off << OFF_SHIFT);

   always_comb begin
      pc4_ext = '0;
      pc4_ext[ADDR_W-1:0] = pc_plus4;
      j_ext = calc_j_tgt(pc4_ext, imm26, OFF_SHIFT);
      j_tgt = j_ext[ADDR_W-1:0];
   end

   // An empty-stack return falls back to the register operand, like jr.
   always_comb begin
      sel = SEL_SEQ;
      if (ret && !ras_empty) sel = SEL_RET;
      else if (ret || jr)    sel = SEL_JR;
      else if (jump)         sel = SEL_J;
      else if (pc_src)       sel = SEL_BR;
   end

   always_comb begin
      target = pc_plus4;
      unique case (sel)
         SEL_RET: target = ras_top;
         SEL_JR:  target = rs_val;
         SEL_J:   target = j_tgt;
         SEL_BR:  target = br_tgt;
         default: target = pc_plus4;
      endcase
   end

   assign ras_push = link && !stall;
   assign ras_pop  = ret && !ras_empty && !stall;

   ras_stack #(
      .DEPTH(RAS_DEPTH),
      .WIDTH(ADDR_W)
   ) u_ras (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (ras_push),
      .pop      (ras_pop),
      .push_data(pc_plus4),
      .top      (ras_top),
      .empty    (ras_empty),
      .full     (ras_full)
   );

`ifdef NEXT_PC_MISALIGN_TRAP_EN
   logic trap;
   assign trap = |target[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_VEC;
         misalign <= 1'b0;
      end else begin
         misalign <= !stall && trap;
         if (!stall) pc <= trap ? TRAP_VEC : target;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pc <= RESET_VEC;
      else if (!stall) pc <= target;
   end
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (default parameters).
module tb_next_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        pc_src;
   logic        jump;
   logic        jr;
   logic        link;
   logic        ret;
   logic [25:0] imm26;
   logic [31:0] sext_off;
   logic [31:0] rs_val;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        ras_empty;
   logic        ras_full;
`ifdef NEXT_PC_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int checks   = 0;
   int failures = 0;

   next_pc_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall    (stall),
      .pc_src   (pc_src),
      .jump     (jump),
      .jr       (jr),
      .link     (link),
      .ret      (ret),
      .imm26    (imm26),
      .sext_off (sext_off),
      .rs_val   (rs_val),
      .pc       (pc),
      .pc_plus4 (pc_plus4),
      .ras_empty(ras_empty),
`ifdef NEXT_PC_MISALIGN_TRAP_EN
      .misalign (misalign),
`endif
      .ras_full (ras_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; pc_src = 0; jump = 0; jr = 0; link = 0; ret = 0;
      imm26 = '0; sext_off = '0; rs_val = '0;
   endtask

   task automatic go_jr(input logic [31:0] addr);
      idle();
      jr = 1; rs_val = addr;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst_n = 0;
      #12;
      check("reset_pc", pc, 32'h0);
      check("reset_empty", 32'(ras_empty), 32'd1);
      check("reset_full", 32'(ras_full), 32'd0);
      @(negedge clk);
      rst_n = 1;

      step(); check("seq_4", pc, 32'h4);
      step(); check("seq_8", pc, 32'h8);
      step(); check("seq_c", pc, 32'hC);

      // Asynchronous reset in the middle of a cycle
      #2 rst_n = 0;
      #1 check("async_reset_pc", pc, 32'h0);
      #1 rst_n = 1;
      step(); check("after_reset_seq", pc, 32'h4);

      go_jr(32'h100); check("jr_100", pc, 32'h100);
      pc_src = 1; sext_off = 32'hFFFF_FFFE;
      step(); idle(); check("branch_back", pc, 32'hFC);

      go_jr(32'h100);
      pc_src = 1; sext_off = 32'hFFFF_FFFE; jump = 1; imm26 = 26'h40;
      step(); idle(); check("jump_over_branch", pc, 32'h100);

      go_jr(32'h400);
      jump = 1; link = 1; imm26 = 26'h200;
      step(); idle();
      check("jal_pc", pc, 32'h800);
      check("jal_not_empty", 32'(ras_empty), 32'd0);
      step(); check("seq_804", pc, 32'h804);
      ret = 1; rs_val = 32'h1234;
      step(); idle();
      check("ret_404", pc, 32'h404);
      check("ret_empty", 32'(ras_empty), 32'd1);

      // Five pushes into a four-entry stack; oldest (0x10) is overwritten
      go_jr(32'hC);
      for (int i = 1; i <= 5; i++) begin
         link = 1; jr = 1; rs_val = 32'h10 * i + 32'hC;
         step();
      end
      idle();
      check("push5_pc", pc, 32'h5C);
      check("push5_full", 32'(ras_full), 32'd1);
      for (int i = 0; i < 4; i++) begin
         ret = 1; rs_val = 32'hDEAD0;
         step();
         check($sformatf("pop_%0d", i), pc, 32'h50 - 32'h10 * i);
      end
      idle();
      check("pop4_empty", 32'(ras_empty), 32'd1);
      check("pop4_not_full", 32'(ras_full), 32'd0);
      ret = 1; rs_val = 32'h999C;
      step(); idle();
      check("ret_empty_fallback", pc, 32'h999C);

      // Stall holds PC and RAS even with jump and link asserted
      stall = 1; jump = 1; link = 1; imm26 = 26'h100;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stall_pc_%0d", i), pc, 32'h999C);
         check($sformatf("stall_empty_%0d", i), 32'(ras_empty), 32'd1);
      end
      stall = 0; link = 0;
      step(); idle();
      check("stall_release_jump", pc, 32'h400);

      // pc_plus4 wrap at the top of the address space
      go_jr(32'hFFFF_FFFC);
      check("pc_plus4_wrap", pc_plus4, 32'h0);
      step(); check("pc_wrap", pc, 32'h0);

      go_jr(32'h1002);
`ifdef NEXT_PC_MISALIGN_TRAP_EN
      check("misalign_trap_pc", pc, 32'h80);
      check("misalign_pulse", 32'(misalign), 32'd1);
      step();
      check("misalign_clear", 32'(misalign), 32'd0);
      check("trap_seq", pc, 32'h84);
`else
      check("misalign_passthrough", pc, 32'h1002);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
